// File: rtl/apuracao_pkg.sv
// Shared constants and state encoding for the vote-tally block.
package apuracao_pkg;

   localparam logic [2:0] ARTHUR      = 3'd0;
   localparam logic [2:0] LEANDRO     = 3'd1;
   localparam logic [2:0] MATEUS      = 3'd2;
   localparam logic [2:0] PABLO       = 3'd3;
   localparam logic [2:0] NULO        = 3'd4;
   localparam logic [2:0] WINNER_NONE = 3'd7;

   localparam logic [1:0] VOTO_CAND = 2'd1;
   localparam logic [1:0] VOTO_NULO = 2'd3;

   typedef enum logic [1:0] {
      ST_VOTING = 2'd0,
      ST_SCAN   = 2'd1,
      ST_REPORT = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/apuracao_contador_sat.sv
// Saturating up-counter; sat_hit flags an increment lost because the counter is already full.
module contador_sat #(
   parameter int COUNT_W = 8
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               inc,
   output logic [COUNT_W-1:0] value,
   output logic               sat_hit
);

   logic [COUNT_W-1:0] r_value;
   logic               w_at_max;

   assign w_at_max = &r_value;
   assign value    = r_value;
   assign sat_hit  = inc & w_at_max;

   always_ff @(posedge clock) begin
      if (clear) begin
         r_value <= '0;
      end else if (inc && !w_at_max) begin
         r_value <= r_value + COUNT_W'(1);
      end
   end

endmodule

// File: rtl/apuracao.sv
// Vote tally: counts one vote per rising edge of the ballot flags, picks the winner on close,
// then streams the five counts out over a valid/ready port.
//
// state     | meaning
// VOTING    | counting new confirmations, waiting for close
// SCAN      | four cycles comparing the named candidates
// REPORT    | streaming records for IDs 0..4
// DONE      | stream complete, hold until reset
module apuracao
   import apuracao_pkg::*;
#(
   parameter int COUNT_W = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cand_arthur,
   input  logic                 cand_leandro,
   input  logic                 cand_mateus,
   input  logic                 cand_pablo,
   input  logic                 cand_nulo,
   input  logic [1:0]           voto_valido,
   input  logic                 close,
   input  logic                 rep_ready,
   output logic                 rep_valid,
   output logic [2:0]           rep_id,
   output logic [COUNT_W-1:0]   rep_count,
   output logic [2:0]           winner,
   output logic                 tie,
   output logic [COUNT_W+2:0]   total,
   output logic                 done,
   output logic                 err_protocol,
   output logic                 saturated
);

   state_t               r_state, w_state_nxt;
   logic                 r_prev_any;
   logic [COUNT_W+2:0]   r_total;
   logic                 r_err, r_sat;
   logic [1:0]           r_scan_idx;
   logic [COUNT_W-1:0]   r_max;
   logic [2:0]           r_best;
   logic                 r_best_tie;
   logic [2:0]           r_winner;
   logic                 r_tie;
   logic [2:0]           r_rep_id;

   logic [3:0]           w_named;
   logic                 w_any_in, w_event, w_bad_vote;
   logic [4:0]           w_inc, w_sat_hit;
   logic [COUNT_W-1:0]   w_count [5];
   logic [COUNT_W-1:0]   w_scan_cnt, w_rep_cnt, w_max_nxt;
   logic [2:0]           w_best_nxt;
   logic                 w_tie_nxt;

   assign w_named  = {cand_pablo, cand_mateus, cand_leandro, cand_arthur};
   assign w_any_in = (|w_named) | cand_nulo;
   assign w_event  = w_any_in & ~r_prev_any & (r_state == ST_VOTING);

   // Malformed events (several flags, code mismatch) are still counted, as null votes.
   always_comb begin
      w_inc      = '0;
      w_bad_vote = 1'b0;
      if (w_event) begin
         if (!cand_nulo && voto_valido == VOTO_CAND) begin
            case (w_named)
               4'b0001: w_inc[ARTHUR]  = 1'b1;
               4'b0010: w_inc[LEANDRO] = 1'b1;
               4'b0100: w_inc[MATEUS]  = 1'b1;
               4'b1000: w_inc[PABLO]   = 1'b1;
               default: begin
                  w_inc[NULO] = 1'b1;
                  w_bad_vote  = 1'b1;
               end
            endcase
         end else if (w_named == 4'b0000 && cand_nulo && voto_valido == VOTO_NULO) begin
            w_inc[NULO] = 1'b1;
         end else begin
            w_inc[NULO] = 1'b1;
            w_bad_vote  = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < 5; g++) begin : g_cnt
      contador_sat #(.COUNT_W(COUNT_W)) u_cnt (
         .clock   (clock),
         .clear   (reset),
         .inc     (w_inc[g]),
         .value   (w_count[g]),
         .sat_hit (w_sat_hit[g])
      );
   end

   always_comb begin
      w_scan_cnt = w_count[0];
      case (r_scan_idx)
         2'd0:    w_scan_cnt = w_count[0];
         2'd1:    w_scan_cnt = w_count[1];
         2'd2:    w_scan_cnt = w_count[2];
         default: w_scan_cnt = w_count[3];
      endcase
   end

   always_comb begin
      w_rep_cnt = '0;
      case (r_rep_id)
         3'd0:    w_rep_cnt = w_count[0];
         3'd1:    w_rep_cnt = w_count[1];
         3'd2:    w_rep_cnt = w_count[2];
         3'd3:    w_rep_cnt = w_count[3];
         3'd4:    w_rep_cnt = w_count[4];
         default: w_rep_cnt = '0;
      endcase
   end

   // Strict > keeps the lowest ID on ties; a shared zero is not a tie.
   always_comb begin
      w_max_nxt  = r_max;
      w_best_nxt = r_best;
      w_tie_nxt  = r_best_tie;
      if (w_scan_cnt > r_max) begin
         w_max_nxt  = w_scan_cnt;
         w_best_nxt = {1'b0, r_scan_idx};
         w_tie_nxt  = 1'b0;
      end else if (w_scan_cnt == r_max && r_max != '0) begin
         w_tie_nxt  = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_VOTING: if (close) w_state_nxt = ST_SCAN;
         ST_SCAN:   if (r_scan_idx == 2'd3) w_state_nxt = ST_REPORT;
         ST_REPORT: if (rep_ready && r_rep_id == NULO) w_state_nxt = ST_DONE;
         default:   w_state_nxt = ST_DONE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_VOTING;
         r_prev_any <= w_any_in;
         r_total    <= '0;
         r_err      <= 1'b0;
         r_sat      <= 1'b0;
         r_scan_idx <= '0;
         r_max      <= '0;
         r_best     <= WINNER_NONE;
         r_best_tie <= 1'b0;
         r_winner   <= WINNER_NONE;
         r_tie      <= 1'b0;
         r_rep_id   <= ARTHUR;
      end else begin
         r_state    <= w_state_nxt;
         r_prev_any <= w_any_in;
         if (w_event)      r_total <= r_total + (COUNT_W+3)'(1);
         if (w_bad_vote)   r_err   <= 1'b1;
         if (|w_sat_hit)   r_sat   <= 1'b1;
         if (r_state == ST_SCAN) begin
            r_scan_idx <= r_scan_idx + 2'd1;
            r_max      <= w_max_nxt;
            r_best     <= w_best_nxt;
            r_best_tie <= w_tie_nxt;
            if (r_scan_idx == 2'd3) begin
               r_winner <= w_best_nxt;
               r_tie    <= w_tie_nxt;
            end
         end
         if (r_state == ST_REPORT && rep_ready && r_rep_id != NULO)
            r_rep_id <= r_rep_id + 3'd1;
      end
   end

   assign rep_valid    = (r_state == ST_REPORT);
   assign rep_id       = r_rep_id;
   assign rep_count    = rep_valid ? w_rep_cnt : '0;
   assign winner       = r_winner;
   assign tie          = r_tie;
   assign total        = r_total;
   assign done         = (r_state == ST_DONE);
   assign err_protocol = r_err;
   assign saturated    = r_sat;

endmodule
